pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl_if.sv | 31 +++
 rtl/pc_seq_ctrl.sv | 119 +++++++++++
 tb/tb_pc_seq_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: pipeline <-> PC sequencing controller bundle.
//   Decode side (driven by master): irq_in, pc_kernel, instr_valid, mem_busy,
//     op_illegal, op_jr, op_jump, op_branch.
//   Control side (driven by slave): PCSrc[2:0], epc_we, cause[1:0], irq_ack, flush.
interface pc_seq_ctrl_if;
  logic       irq_in;
  logic       pc_kernel;
  logic       instr_valid;
  logic       mem_busy;
  logic       op_illegal;
  logic       op_jr;
  logic       op_jump;
  logic       op_branch;
  logic [2:0] PCSrc;
  logic       epc_we;
  logic [1:0] cause;
  logic       irq_ack;
  logic       flush;

  modport master (
    output irq_in, pc_kernel, instr_valid, mem_busy,
           op_illegal, op_jr, op_jump, op_branch,
    input  PCSrc, epc_we, cause, irq_ack, flush
  );

  modport slave (
    input  irq_in, pc_kernel, instr_valid, mem_busy,
           op_illegal, op_jr, op_jump, op_branch,
    output PCSrc, epc_we, cause, irq_ack, flush
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC select and trap sequencing.
//   clk, reset : single clock, synchronous active-high reset.
//   bus        : pc_seq_ctrl_if.slave -- decode class / mode / irq in,
//                PCSrc, epc_we, cause, irq_ack, flush out.
// A trap (illegal op or accepted interrupt) is decided combinationally in RUN
// and followed by exactly one TRAP cycle that holds the PC and flushes fetch.
// Interrupts are only taken in user mode, and not during a short shadow of
// SHADOW_LEN (0..3) retired instructions after a kernel-to-user transition.
module pc_seq_ctrl #(
  parameter int SHADOW_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  pc_seq_ctrl_if.slave bus
);

  localparam logic [1:0] SH_INIT = 2'(SHADOW_LEN);

  localparam logic [2:0] PC_SEQ  = 3'b000;
  localparam logic [2:0] PC_BR   = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  localparam logic [2:0] PC_JR   = 3'b011;
  localparam logic [2:0] PC_IRQ  = 3'b100;
  localparam logic [2:0] PC_EXC  = 3'b101;
  localparam logic [2:0] PC_HOLD = 3'b111;

  localparam logic [1:0] CAUSE_IRQ = 2'b01;
  localparam logic [1:0] CAUSE_ILL = 2'b10;

  typedef enum logic {RUN, TRAP} state_t;

  state_t     state, state_nxt;
  logic [2:0] sync;        // [0],[1] synchronizer, [2] delayed copy for edge detect
  logic       irq_pend;
  logic       kpc_q;       // registered pc_kernel
  logic [1:0] shadow, shadow_eff, shadow_nxt;
  logic [1:0] cause_q, cause_nxt;
  logic       irq_edge, k_fall, retire, take_irq;
  logic [2:0] pc_src;
  logic       epc_we, irq_ack, flush;

  assign irq_edge = sync[1] & ~sync[2];
  assign k_fall   = kpc_q & ~bus.pc_kernel;

  // The instruction issued in the first user cycle already counts as the
  // first shadow instruction, so the reload is visible in the same cycle.
  assign shadow_eff = k_fall ? SH_INIT : shadow;
  assign shadow_nxt = (retire && shadow_eff != 2'd0) ? shadow_eff - 2'd1 : shadow_eff;

  always_comb begin
    state_nxt = state;
    pc_src    = PC_HOLD;
    epc_we    = 1'b0;
    irq_ack   = 1'b0;
    flush     = 1'b0;
    cause_nxt = cause_q;
    take_irq  = 1'b0;
    retire    = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (bus.instr_valid && !bus.mem_busy) begin
            if (bus.op_illegal) begin
              pc_src    = PC_EXC;
              epc_we    = 1'b1;
              cause_nxt = CAUSE_ILL;
              state_nxt = TRAP;
            end else if (irq_pend && !bus.pc_kernel && shadow_eff == 2'd0) begin
              pc_src    = PC_IRQ;
              epc_we    = 1'b1;
              irq_ack   = 1'b1;
              take_irq  = 1'b1;
              cause_nxt = CAUSE_IRQ;
              state_nxt = TRAP;
            end else begin
              retire = 1'b1;
              if (bus.op_jr)          pc_src = PC_JR;
              else if (bus.op_jump)   pc_src = PC_JMP;
              else if (bus.op_branch) pc_src = PC_BR;
              else                    pc_src = PC_SEQ;
            end
          end
        end
        TRAP: begin
          flush     = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      sync     <= 3'b000;
      irq_pend <= 1'b0;
      kpc_q    <= 1'b1;
      shadow   <= 2'd0;
      cause_q  <= 2'b00;
    end else begin
      state   <= state_nxt;
      sync    <= {sync[1:0], bus.irq_in};
      kpc_q   <= bus.pc_kernel;
      shadow  <= shadow_nxt;
      cause_q <= cause_nxt;
      // An edge landing on the acceptance cycle re-arms the pending flag.
      if (take_irq)      irq_pend <= irq_edge;
      else if (irq_edge) irq_pend <= 1'b1;
    end
  end

  assign bus.PCSrc   = pc_src;
  assign bus.epc_we  = epc_we;
  assign bus.irq_ack = irq_ack;
  assign bus.flush   = flush;
  assign bus.cause   = cause_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: decode table, hand-written trap/interrupt sequences and a
// randomized run, all compared against a behavioural model every cycle.
module tb_pc_seq_ctrl;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_seq_ctrl_if bus();
  pc_seq_ctrl #(.SHADOW_LEN(SH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // ---- behavioural model ----
  bit         m_pend, m_trap, m_prevk;
  int         m_sh;
  logic [1:0] m_cause;
  bit         irqh[$];     // irq_in samples, newest first
  logic [2:0] e_pc;
  bit         e_epc, e_ack, e_fl, e_tirq, e_till, e_ret;
  int         e_shleft;

  function automatic void model_eval();
    e_pc = 3'b111; e_epc = 0; e_ack = 0; e_fl = 0;
    e_tirq = 0; e_till = 0; e_ret = 0;
    e_shleft = (m_prevk && !bus.pc_kernel) ? SH : m_sh;
    if (reset) begin
    end else if (m_trap) begin
      e_fl = 1;
    end else if (!bus.instr_valid || bus.mem_busy) begin
    end else if (bus.op_illegal) begin
      e_pc = 3'b101; e_epc = 1; e_till = 1;
    end else if (m_pend && !bus.pc_kernel && e_shleft == 0) begin
      e_pc = 3'b100; e_epc = 1; e_ack = 1; e_tirq = 1;
    end else begin
      e_ret = 1;
      e_pc = bus.op_jr ? 3'b011 : bus.op_jump ? 3'b010 : bus.op_branch ? 3'b001 : 3'b000;
    end
  endfunction

  function automatic void model_update();
    bit edge_seen;
    if (reset) begin
      m_pend = 0; m_trap = 0; m_cause = 2'b00; m_sh = 0; m_prevk = 1;
      irqh = '{0, 0, 0};
    end else begin
      // synchronized level is the sample from two edges back
      edge_seen = irqh[1] && !irqh[2];
      if (e_tirq)         m_pend = edge_seen;
      else if (edge_seen) m_pend = 1;
      if (e_till) m_cause = 2'b10;
      if (e_tirq) m_cause = 2'b01;
      m_trap  = e_till || e_tirq;
      m_sh    = (e_ret && e_shleft > 0) ? e_shleft - 1 : e_shleft;
      m_prevk = bus.pc_kernel;
      irqh.push_front(bus.irq_in);
      void'(irqh.pop_back());
    end
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // packed as {PCSrc, epc_we, irq_ack, flush, cause}
  task automatic step(input string tag, input bit use_c, input logic [2:0] pc,
                      input bit epc, input bit ack, input bit fl, input logic [1:0] ca);
    @(negedge clk);
    model_eval();
    chk({tag, ".model"}, {bus.PCSrc, bus.epc_we, bus.irq_ack, bus.flush, bus.cause},
        {e_pc, e_epc, e_ack, e_fl, m_cause});
    if (use_c)
      chk({tag, ".const"}, {bus.PCSrc, bus.epc_we, bus.irq_ack, bus.flush, bus.cause},
          {pc, epc, ack, fl, ca});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drv(input bit v, input bit b, input bit k, input bit il,
                     input bit jr, input bit jp, input bit br);
    bus.instr_valid = v; bus.mem_busy = b; bus.pc_kernel = k;
    bus.op_illegal = il; bus.op_jr = jr; bus.op_jump = jp; bus.op_branch = br;
  endtask

  typedef struct {
    bit v, b, k, il, jr, jp, br;
    logic [2:0] pc;
    bit epc, fl;
    logic [1:0] ca;
  } vec_t;
  vec_t tbl[13];

  initial begin
    //         v  b  k  il jr jp br  pc      epc fl ca
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 2'b00};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 3'b111, 0, 0, 2'b00};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 2'b00};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 0, 3'b010, 0, 0, 2'b00};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, 3'b011, 0, 0, 2'b00};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 1, 3'b011, 0, 0, 2'b00};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 1, 3'b010, 0, 0, 2'b00};
    tbl[8]  = '{1, 0, 1, 0, 0, 1, 0, 3'b010, 0, 0, 2'b00};
    tbl[9]  = '{1, 1, 0, 1, 0, 0, 0, 3'b111, 0, 0, 2'b00};
    tbl[10] = '{1, 0, 0, 1, 1, 0, 0, 3'b101, 1, 0, 2'b00};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 0, 3'b111, 0, 1, 2'b10};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b10};

    // reset overrides an illegal op on the inputs
    reset = 1'b1; bus.irq_in = 1'b0;
    drv(1, 0, 0, 1, 0, 0, 0);
    @(posedge clk); model_update(); #1;
    step("rst0", 1, 3'b111, 0, 0, 0, 2'b00);
    step("rst1", 1, 3'b111, 0, 0, 0, 2'b00);
    reset = 1'b0;

    // decode priority and single illegal trap
    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].v, tbl[i].b, tbl[i].k, tbl[i].il, tbl[i].jr, tbl[i].jp, tbl[i].br);
      step($sformatf("tbl%0d", i), 1, tbl[i].pc, tbl[i].epc, 1'b0, tbl[i].fl, tbl[i].ca);
    end

    // irq edge -> accepted on the third cycle after the edge
    drv(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("a_pre", 1, 3'b000, 0, 0, 0, 2'b10);
    bus.irq_in = 1'b1;
    for (int i = 0; i < 3; i++) step("a_wait", 1, 3'b000, 0, 0, 0, 2'b10);
    step("a_acc", 1, 3'b100, 1, 1, 0, 2'b10);
    step("a_trap", 1, 3'b111, 0, 0, 1, 2'b01);

    // pending irq held through kernel mode, then shadow of two instructions
    drv(1, 0, 1, 0, 0, 0, 0); bus.irq_in = 1'b0;
    for (int i = 0; i < 3; i++) step("b_k0", 1, 3'b000, 0, 0, 0, 2'b01);
    bus.irq_in = 1'b1;
    for (int i = 0; i < 7; i++) step("b_k1", 1, 3'b000, 0, 0, 0, 2'b01);
    drv(1, 0, 0, 0, 0, 0, 0);
    step("b_sh1", 1, 3'b000, 0, 0, 0, 2'b01);
    step("b_sh2", 1, 3'b000, 0, 0, 0, 2'b01);
    step("b_acc", 1, 3'b100, 1, 1, 0, 2'b01);
    step("b_trap", 1, 3'b111, 0, 0, 1, 2'b01);

    // illegal beats pending irq; irq survives the kernel-mode handler
    drv(0, 0, 0, 0, 0, 0, 0); bus.irq_in = 1'b0;
    for (int i = 0; i < 2; i++) step("c_lo", 1, 3'b111, 0, 0, 0, 2'b01);
    bus.irq_in = 1'b1;
    for (int i = 0; i < 4; i++) step("c_hi", 1, 3'b111, 0, 0, 0, 2'b01);
    drv(1, 0, 0, 1, 0, 0, 0);
    step("c_ill", 1, 3'b101, 1, 0, 0, 2'b01);
    drv(1, 0, 1, 0, 0, 0, 0);
    step("c_trap", 1, 3'b111, 0, 0, 1, 2'b10);
    for (int i = 0; i < 3; i++) step("c_kern", 1, 3'b000, 0, 0, 0, 2'b10);
    drv(1, 0, 0, 0, 0, 0, 0);
    step("c_sh1", 1, 3'b000, 0, 0, 0, 2'b10);
    step("c_sh2", 1, 3'b000, 0, 0, 0, 2'b10);
    step("c_acc", 1, 3'b100, 1, 1, 0, 2'b10);
    step("c_trap2", 1, 3'b111, 0, 0, 1, 2'b01);

    // mem_busy stalls both traps; illegal taken first once it clears
    drv(0, 0, 0, 0, 0, 0, 0); bus.irq_in = 1'b0;
    for (int i = 0; i < 2; i++) step("d_lo", 1, 3'b111, 0, 0, 0, 2'b01);
    bus.irq_in = 1'b1;
    for (int i = 0; i < 4; i++) step("d_hi", 1, 3'b111, 0, 0, 0, 2'b01);
    drv(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("d_busy", 1, 3'b111, 0, 0, 0, 2'b01);
    drv(1, 0, 0, 1, 0, 0, 0);
    step("d_ill", 1, 3'b101, 1, 0, 0, 2'b01);
    drv(1, 0, 0, 0, 0, 0, 0);
    step("d_trap", 1, 3'b111, 0, 0, 1, 2'b10);
    step("d_acc", 1, 3'b100, 1, 1, 0, 2'b10);
    step("d_trap2", 1, 3'b111, 0, 0, 1, 2'b01);

    // reset during the trap cycle drops the trap and the pending irq
    drv(0, 0, 0, 0, 0, 0, 0); bus.irq_in = 1'b0;
    for (int i = 0; i < 2; i++) step("e_lo", 1, 3'b111, 0, 0, 0, 2'b01);
    bus.irq_in = 1'b1;
    for (int i = 0; i < 4; i++) step("e_hi", 1, 3'b111, 0, 0, 0, 2'b01);
    drv(1, 0, 0, 1, 0, 0, 0); bus.irq_in = 1'b0;
    step("e_ill", 1, 3'b101, 1, 0, 0, 2'b01);
    drv(1, 0, 0, 0, 0, 0, 0); reset = 1'b1;
    step("e_rst", 1, 3'b111, 0, 0, 0, 2'b10);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("e_post", 1, 3'b000, 0, 0, 0, 2'b00);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0)  bus.irq_in    = ~bus.irq_in;
      if ($urandom_range(15) == 0) bus.pc_kernel = ~bus.pc_kernel;
      bus.instr_valid = ($urandom_range(99) < 85);
      bus.mem_busy    = ($urandom_range(5) == 0);
      bus.op_illegal  = ($urandom_range(15) == 0);
      bus.op_jr       = ($urandom_range(3) == 0);
      bus.op_jump     = ($urandom_range(3) == 0);
      bus.op_branch   = ($urandom_range(3) == 0);
      step("rnd", 0, 3'b000, 0, 0, 0, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
